serial_sub_ctrl: RTL and testbench
==================================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled on the rising clk edge.
REQ-005 a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while the bit-serial operation is in progress.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 diff  output  WIDTH  registered result a - b, modulo 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow; 1 iff unsigned a < b.
REQ-011 ovf  output  1  signed overflow of a - b in two's complement.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL latch a and b into internal shift registers, clear the running borrow and the bit counter, and go to RUN; start=0 SHALL leave IDLE.
REQ-014 RUN: each edge SHALL process one bit, LSB first, using one half-subtractor stage plus borrow-in: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
REQ-015 RUN: each edge SHALL shift both operand registers right by one, shift d into the MSB of the result register, register bout as the next bin, and increment the counter.
REQ-016 After the WIDTH-th RUN edge the FSM SHALL go to DONE and, on that same edge, load diff, borrow_out (= final bout) and ovf (= (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands).
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both registered or state-decoded, glitch-free.
REQ-019 Latency: with start accepted at edge E0, done SHALL be high in the cycle after edge E(WIDTH), and diff/borrow_out/ovf SHALL be valid from that same cycle.
REQ-020 start while in RUN or DONE SHALL be ignored (no queueing); a new request is accepted only in IDLE, so the minimum start-to-start spacing is WIDTH+2 cycles.
REQ-021 Changes on a or b after the accepting edge SHALL NOT affect the in-flight result.
REQ-022 diff, borrow_out and ovf SHALL hold their last values until the next completion overwrites them.
REQ-023 The counter SHALL be wide enough for WIDTH without wrap before the terminal compare; no counter wrap SHALL occur in any state.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, diff=0, borrow_out=0, ovf=0, and clear the counter, borrow and shift registers.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first edge with rst_n=1 and start=1 SHALL begin a fresh operation.

Verification (WIDTH=8)
REQ-026 a=0x05, b=0x03, 1-cycle start -> busy high for 8 cycles, done pulse 1 cycle, diff=0x02, borrow_out=0, ovf=0.
REQ-027 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, ovf=0; a=0x00, b=0x00 -> diff=0x00, borrow_out=0, ovf=0.
REQ-028 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
REQ-029 start held high continuously, a/b changed every cycle -> each result matches operands at its accepting edge; done pulses every 10 cycles.
REQ-030 rst_n pulsed low during the 4th RUN cycle -> all outputs 0 asynchronously, no done pulse; subsequent a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0.
REQ-031 start pulsed in DONE cycle -> ignored, FSM stays IDLE, outputs held.

Source files
------------

// File: rtl/serial_sub_ctrl_if.sv
// Bus bundle for the bit-serial subtractor: request side (start/a/b) and
// result side (busy/done/diff/borrow_out/ovf).
interface serial_sub_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;

    // Requester drives operands, subtractor returns status and result.
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, ovf
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, then
// publishes diff, the final borrow and the signed overflow flag for one
// DONE cycle. Results hold until the next completion.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_ctrl_if.slave   bus
);

    // Wide enough to hold WIDTH itself, so the final increment never wraps.
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              bin_q, bin_d;
    // Operand sign bits are kept aside because the shift registers lose them.
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;
    logic              ovf_q, ovf_d;

    logic              sub_d;
    logic              sub_bout;

    // One full-subtractor stage on the current LSBs.
    always_comb begin
        sub_d    = a_sh_q[0] ^ b_sh_q[0] ^ bin_q;
        sub_bout = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bin_q);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {sub_d, res_q[WIDTH-1:1]};
                bin_d  = sub_bout;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d  = StDone;
                    diff_d   = res_d;
                    borrow_d = sub_bout;
                    // The bit just produced is the result MSB.
                    ovf_d    = (a_msb_q != b_msb_q) && (sub_d != a_msb_q);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // Status is decoded straight from the state register.
    assign bus.busy       = (state_q == StRun);
    assign bus.done       = (state_q == StDone);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized bench for serial_sub_ctrl (WIDTH=8) against an arithmetic model,
// plus literal expectations for the hand-worked operand pairs.
module tb_serial_sub_ctrl;

    localparam int W    = 8;
    localparam int SMax = 2 ** (W - 1) - 1;
    localparam int SMin = -(2 ** (W - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(W)) bus ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    // Model: k = cycles since acceptance (0 = idle), results from plain arithmetic.
    int           k = 0;
    logic [W-1:0] la = '0, lb = '0, ediff = '0;
    logic         ebor = 1'b0, eovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k     <= 0;
            ediff <= '0;
            ebor  <= 1'b0;
            eovf  <= 1'b0;
        end else if (k == 0) begin
            if (bus.start) begin
                k  <= 1;
                la <= bus.a;
                lb <= bus.b;
            end
        end else if (k <= W) begin
            k <= k + 1;
            if (k == W) begin
                ediff <= la - lb;
                ebor  <= (la < lb);
                eovf  <= ((int'($signed(la)) - int'($signed(lb))) > SMax) ||
                         ((int'($signed(la)) - int'($signed(lb))) < SMin);
            end
        end else begin
            k <= 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        checks++;
        if (bus.busy !== (k >= 1 && k <= W) || bus.done !== (k == W + 1) ||
            bus.diff !== ediff || bus.borrow_out !== ebor || bus.ovf !== eovf) begin
            failures++;
            $display("FAIL cycle_compare t=%0t busy=%b/%b done=%b/%b diff=%h/%h bor=%b/%b ovf=%b/%b",
                     $time, bus.busy, (k >= 1 && k <= W), bus.done, (k == W + 1),
                     bus.diff, ediff, bus.borrow_out, ebor, bus.ovf, eovf);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one request from an idle cycle; scrambles a/b while in flight.
    // Returns at the negedge of the DONE cycle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int busy_cnt, output bit ok);
        busy_cnt = 0;
        ok = 1'b0;
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic directed(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] ed, input logic eb, input logic eo);
        int  bc;
        bit  ok;
        @(negedge clk);
        run_op(av, bv, bc, ok);
        chk({name, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({name, "_borrow"}, 32'(bus.borrow_out), 32'(eb));
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
        chk({name, "_busy_cycles"}, 32'(bc), 32'(W));
    endtask

    initial begin
        int  bc;
        bit  ok;
        int  prev_done;
        logic [W-1:0] held;

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #1;
        chk("reset_busy", 32'(bus.busy), 32'(0));
        chk("reset_done", 32'(bus.done), 32'(0));
        chk("reset_diff", 32'(bus.diff), 32'(0));
        chk("reset_borrow", 32'(bus.borrow_out), 32'(0));
        chk("reset_ovf", 32'(bus.ovf), 32'(0));
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;

        directed("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        directed("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        directed("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        directed("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        directed("sub_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Start pulsed during DONE must be dropped.
        held = bus.diff;
        bus.start = 1'b1;
        bus.a = 8'h11;
        bus.b = 8'h22;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_start_busy", 32'(bus.busy), 32'(0));
        chk("done_start_diff_held", 32'(bus.diff), 32'(held));
        @(negedge clk);
        chk("done_start_still_idle", 32'(bus.busy), 32'(0));

        // Reset during the 4th RUN cycle.
        bus.a = 8'h55;
        bus.b = 8'h22;
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("midrun_busy_before", 32'(bus.busy), 32'(1));
        #3 rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 32'(bus.busy), 32'(0));
        chk("midrun_rst_done", 32'(bus.done), 32'(0));
        chk("midrun_rst_diff", 32'(bus.diff), 32'(0));
        chk("midrun_rst_borrow", 32'(bus.borrow_out), 32'(0));
        chk("midrun_rst_ovf", 32'(bus.ovf), 32'(0));
        @(negedge clk);
        #3 rst_n = 1'b1;
        directed("post_rst_ff_01", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);

        // Random single requests with random idle gaps.
        for (int n = 0; n < 25; n++) begin
            int gap;
            gap = int'($urandom_range(1, 4));
            for (int g = 0; g < gap; g++) @(negedge clk);
            run_op(W'($urandom), W'($urandom), bc, ok);
        end

        // Start held high with operands changing every cycle.
        @(negedge clk);
        bus.start = 1'b1;
        prev_done = -1;
        for (int i = 0; i < 65; i++) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            @(negedge clk);
            if (bus.done) begin
                if (prev_done >= 0) chk("done_spacing", 32'(int'(cyc) - prev_done), 32'(W + 2));
                prev_done = int'(cyc);
            end
        end
        bus.start = 1'b0;
        for (int i = 0; i < W + 4; i++) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
